// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-granular arbiter sharing one FIFO write port among NREQ producers.
// Beats pass combinationally from the owning producer to the FIFO (zero latency).
module fifo_wr_arbiter #(
    parameter int DATA_W    = 128,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4,
    localparam int IDW      = $clog2(NREQ),
    localparam int CNTW     = $clog2(MAX_BURST + 1)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NREQ-1:0]          i_req,
    input  logic [NREQ*DATA_W-1:0]   i_data,
    input  logic [NREQ-1:0]          i_last,
    output logic [NREQ-1:0]          o_ack,
    output logic                     o_wren,
    output logic [DATA_W-1:0]        o_wrdata,
    input  logic                     i_full,
    input  logic                     i_alm_full,
    output logic [IDW-1:0]           o_grant_id,
    output logic                     o_busy
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]  owner_q, owner_d;
    logic [CNTW-1:0] beat_cnt_q, beat_cnt_d;

    logic            found;
    logic [IDW-1:0]  pick;
    logic [IDW:0]    cand_sum;
    logic [IDW-1:0]  cand;
    logic            beat;
    logic [IDW-1:0]  owner_nxt;

    // First requester at or after rr_ptr, scanning upward modulo NREQ.
    always_comb begin
        found    = 1'b0;
        pick     = '0;
        cand_sum = '0;
        cand     = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand_sum = {1'b0, rr_ptr_q} + (IDW+1)'(i);
            if (cand_sum >= (IDW+1)'(NREQ))
                cand_sum = cand_sum - (IDW+1)'(NREQ);
            cand = cand_sum[IDW-1:0];
            if (!found && i_req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign owner_nxt = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
    assign beat      = (state_q == BURST) && i_req[owner_q] && !i_full;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        o_wren     = 1'b0;
        o_ack      = '0;
        o_wrdata   = '0;
        o_busy     = 1'b0;
        case (state_q)
            IDLE: begin
                if (found && !i_alm_full) begin
                    owner_d    = pick;
                    beat_cnt_d = '0;
                    state_d    = BURST;
                end
            end
            BURST: begin
                o_busy = 1'b1;
                if (beat) begin
                    o_wren     = 1'b1;
                    o_ack      = NREQ'(1) << owner_q;
                    o_wrdata   = i_data[owner_q*DATA_W +: DATA_W];
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (i_last[owner_q] || (beat_cnt_q + 1'b1 == CNTW'(MAX_BURST))) begin
                        state_d  = IDLE;
                        rr_ptr_d = owner_nxt;
                    end
                end else if (!i_req[owner_q]) begin
                    // Owner withdrew: release without writing.
                    state_d  = IDLE;
                    rr_ptr_d = owner_nxt;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign o_grant_id = owner_q;

endmodule
